// File: rtl/writeback_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter.
// Register index/data widths and the queued long-result entry.
package writeback_port_arbiter_pkg;

    localparam int WB_IDX_W  = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_NREGS  = 32;

    typedef struct packed {
        logic [WB_IDX_W-1:0]  index;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small sync FIFO holding long-unit results awaiting a free port.
// Pointers and count reset; storage does not.
module wb_result_fifo
    import writeback_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_din,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written on accepted push.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the regfile write port between the pipeline and long-unit results.
// Also tracks pending long destinations and flags starvation / protocol errors.
module writeback_port_arbiter
    import writeback_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_we,
    input  logic [WB_IDX_W-1:0]  p_index,
    input  logic [WB_DATA_W-1:0] p_data,
    input  logic                 l_valid,
    output logic                 l_ready,
    input  logic [WB_IDX_W-1:0]  l_index,
    input  logic [WB_DATA_W-1:0] l_data,
    input  logic                 claim_valid,
    input  logic [WB_IDX_W-1:0]  claim_index,
    output logic                 we,
    output logic [WB_IDX_W-1:0]  windex,
    output logic [WB_DATA_W-1:0] win,
    output logic [WB_NREGS-1:0]  pend_mask,
    output logic                 stall_pipe,
    output logic                 err
);

    localparam int            CW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;
    wb_entry_t           w_head;
    wb_entry_t           w_entry;
    logic [WB_NREGS-1:0] w_pend_nxt;

    logic [WB_NREGS-1:0] r_pend;
    logic [CW-1:0]       r_cnt;
    logic                r_stall;
    logic                r_stall_d;
    logic                r_err;

    assign l_ready = !w_full;
    assign w_push  = l_valid && !w_full && (l_index != '0);
    assign w_entry = '{index: l_index, data: l_data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Port select: pipeline first, else drain the FIFO head.
    always_comb begin
        we     = 1'b0;
        windex = '0;
        win    = '0;
        w_pop  = 1'b0;
        if (p_we) begin
            we     = 1'b1;
            windex = p_index;
            win    = p_data;
        end else if (!w_empty) begin
            we     = 1'b1;
            windex = w_head.index;
            win    = w_head.data;
            w_pop  = 1'b1;
        end
    end

    // Scoreboard next state: drain clears, a new claim sets and wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_pop) w_pend_nxt[w_head.index] = 1'b0;
        if (claim_valid && (claim_index != '0)) begin
            w_pend_nxt[claim_index] = 1'b1;
        end
    end

    assign w_err_set = p_we &&
                       (((p_index != '0) && r_pend[p_index]) || r_stall_d);

    // Scoreboard, starvation counter, stall and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= '0;
            r_cnt     <= '0;
            r_stall   <= 1'b0;
            r_stall_d <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_empty || !p_we) begin
                r_cnt <= '0;
            end else if (r_cnt != LIM) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_stall   <= !w_pop && !w_empty && (r_cnt >= LIM);
            r_stall_d <= r_stall;
            r_err     <= r_err | w_err_set;
        end
    end

    assign pend_mask  = r_pend;
    assign stall_pipe = r_stall;
    assign err        = r_err;

endmodule
